// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1-style, LSB first) feeding a small first-word-fall-through FIFO.
// Adds start-bit glitch rejection, framing-error and overflow pulses.
module uart_rx_fifo #(
  parameter int CLOCKS_PER_PULSE = 5208,
  parameter int DATA_WIDTH       = 8,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          rx,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          data_valid,
  input  logic                          data_ready,
  output logic                          frame_err,
  output logic                          overflow,
  output logic                          rx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(CLOCKS_PER_PULSE);
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);
  localparam logic [AW:0]   DEPTH    = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e                               state_q, state_d;
  logic                                 rx_meta_q, rx_s_q;
  logic [CW-1:0]                        cnt_q, cnt_d;
  logic [IW-1:0]                        idx_q, idx_d;
  logic [DATA_WIDTH-1:0]                shift_q, shift_d;
  logic                                 frame_ok, frame_bad;

  logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
  logic [AW-1:0]                        wr_ptr_q, rd_ptr_q;
  logic [AW:0]                          count_q, count_d;
  logic                                 pop, push_ok;
  logic                                 frame_err_q, overflow_q;

  // Two-stage synchronizer; idles high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        // Half a bit in: still low means a real start bit, and the counter
        // restarts so every later sample lands mid-bit.
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          if (idx_q == IDX_LAST) state_d = S_STOP;
          else                   idx_d   = idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            frame_ok = 1'b1;
            state_d  = S_IDLE;
          end else begin
            frame_bad = 1'b1;
            state_d   = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BREAK: begin
        // A held-low line must go high again before a new frame can start.
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign pop     = data_ready && (count_q != '0);
  assign push_ok = frame_ok && ((count_q != DEPTH) || pop);

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      frame_err_q <= frame_bad;
      overflow_q  <= frame_ok && !push_ok;
    end
  end

  assign data_out   = mem_q[rd_ptr_q];
  assign data_valid = (count_q != '0);
  assign fifo_count = count_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;
  assign rx_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized and directed bench for uart_rx_fifo; a queue-based model predicts
// FIFO contents and status pulses from frame arrival times.
module tb_uart_rx_fifo;
  localparam int CPP   = 16;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  // Negedge on which rx falls -> model cycle index of the push edge.
  localparam int LAT   = 1 + 2 + (DW * CPP) + (3 * CPP / 2);

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          rx = 1'b1;
  logic          data_ready = 1'b0;
  logic [DW-1:0] data_out;
  logic          data_valid, frame_err, overflow, rx_busy;
  logic [2:0]    fifo_count;

  uart_rx_fifo #(
    .CLOCKS_PER_PULSE(CPP),
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .rx(rx),
    .data_out(data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .frame_err(frame_err),
    .overflow(overflow),
    .rx_busy(rx_busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    bit         good;
    logic [7:0] d;
  } ev_t;

  ev_t        sched[$];
  logic [7:0] mq[$];
  int         cyc = 0;
  bit         exp_fe = 1'b0, exp_ov = 1'b0;
  int         n_chk = 0, n_fail = 0;
  bit         chk_en = 1'b0;
  int         ov_seen = 0, fe_seen = 0;
  bit         rnd_done = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Model: a frame's outcome lands on its push edge; FIFO is a plain queue.
  always @(posedge clk) begin
    bit         pop, acc;
    logic [7:0] d;
    cyc++;
    exp_fe = 1'b0;
    exp_ov = 1'b0;
    if (!rstn) begin
      mq.delete();
      sched.delete();
    end else begin
      pop = data_ready && (mq.size() > 0);
      acc = 1'b0;
      d   = '0;
      if (sched.size() > 0 && sched[0].at == cyc) begin
        d = sched[0].d;
        if (!sched[0].good)                  exp_fe = 1'b1;
        else if (mq.size() < DEPTH || pop)   acc = 1'b1;
        else                                 exp_ov = 1'b1;
        void'(sched.pop_front());
      end
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(d);
    end
  end

  always @(negedge clk) begin
    if (rstn && chk_en) begin
      check("valid", data_valid, mq.size() != 0);
      check("count", fifo_count, mq.size());
      if (mq.size() != 0) check("data", data_out, mq[0]);
      check("frame_err", frame_err, exp_fe);
      check("overflow", overflow, exp_ov);
    end
    if (rstn) begin
      if (frame_err) fe_seen++;
      if (overflow)  ov_seen++;
    end
  end

  // Called right after a negedge; returns right after a negedge with rx high.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int stop_len);
    sched.push_back('{cyc + LAT, stop_ok, d});
    rx = 1'b0;
    repeat (CPP) @(negedge clk);
    for (int i = 0; i < DW; i++) begin
      rx = d[i];
      repeat (CPP) @(negedge clk);
    end
    rx = stop_ok;
    repeat (stop_len) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic pulse_ready();
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, data_valid, 0);
    check({tag, "_dout"},  data_out, 0);
    check({tag, "_ferr"},  frame_err, 0);
    check({tag, "_ovf"},   overflow, 0);
    check({tag, "_busy"},  rx_busy, 0);
    check({tag, "_count"}, fifo_count, 0);
  endtask

  initial begin
    int p, ov0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rstn   = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Single frame, then one-cycle pop.
    send_frame(8'hA5, 1'b1, CPP);
    repeat (4) @(negedge clk);
    check("t1_valid", data_valid, 1);
    check("t1_data", data_out, 8'hA5);
    check("t1_count", fifo_count, 1);
    check("t1_ferr_seen", fe_seen, 0);
    check("t1_busy", rx_busy, 0);
    pulse_ready();
    check("t1_count_after_pop", fifo_count, 0);
    check("t1_valid_after_pop", data_valid, 0);

    // Short low glitch must not start a frame.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    check("t2_busy_in_start", rx_busy, 1);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    check("t2_busy_idle", rx_busy, 0);
    check("t2_count", fifo_count, 0);
    check("t2_ferr_seen", fe_seen, 0);

    // Stop bit low and line held low: one frame error, then recovery.
    send_frame(8'h3C, 1'b0, 40);
    check("t3_busy_break", rx_busy, 1);
    repeat (6) @(negedge clk);
    check("t3_busy_released", rx_busy, 0);
    check("t3_ferr_seen", fe_seen, 1);
    check("t3_count", fifo_count, 0);
    send_frame(8'h81, 1'b1, CPP);
    repeat (2) @(negedge clk);
    check("t3_data", data_out, 8'h81);
    check("t3_count_after", fifo_count, 1);
    pulse_ready();

    // Five frames into a four-deep FIFO with no consumer.
    for (int d = 1; d <= 5; d++) send_frame(8'(d), 1'b1, CPP);
    repeat (2) @(negedge clk);
    check("t4_count_full", fifo_count, 4);
    check("t4_ovf_seen", ov_seen, 1);
    for (int d = 1; d <= 4; d++) begin
      check("t4_drain", data_out, d);
      pulse_ready();
    end
    check("t4_empty", data_valid, 0);

    // Reset in the middle of a frame of all ones.
    rx = 1'b0;
    repeat (CPP) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("t5_busy_mid", rx_busy, 1);
    rstn = 1'b0;
    #1;
    check_all_zero("t5_async");
    repeat (3) @(negedge clk);
    check_all_zero("t5_hold");
    rstn = 1'b1;
    @(negedge clk);
    send_frame(8'h5A, 1'b1, CPP);
    repeat (2) @(negedge clk);
    check("t5_data", data_out, 8'h5A);
    check("t5_count", fifo_count, 1);
    pulse_ready();

    // Full FIFO with a pop on exactly the push edge of the fifth frame.
    for (int d = 1; d <= 4; d++) send_frame(8'(d), 1'b1, CPP);
    ov0 = ov_seen;
    p   = cyc + LAT;
    fork
      send_frame(8'h05, 1'b1, CPP);
      begin
        while (cyc < p - 1) @(negedge clk);
        pulse_ready();
      end
    join
    repeat (2) @(negedge clk);
    check("t6_no_ovf", ov_seen, ov0);
    check("t6_count", fifo_count, 4);
    for (int d = 2; d <= 5; d++) begin
      check("t6_drain", data_out, d);
      pulse_ready();
    end

    // Random frames, random stop bits, random consumer.
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          bit ok;
          ok = ($urandom_range(0, 7) != 0);
          send_frame(8'($urandom), ok, CPP);
          repeat (ok ? $urandom_range(0, 5) : $urandom_range(4, 9)) @(negedge clk);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          data_ready = ($urandom_range(0, 3) == 0);
          @(negedge clk);
        end
        data_ready = 1'b0;
      end
    join
    data_ready = 1'b1;
    repeat (8) @(negedge clk);
    data_ready = 1'b0;
    check("final_empty", fifo_count, 0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "timeout");
  end

endmodule
